// File: rtl/spi_arbiter.sv
// Two-requester arbiter in front of a single SPI master core: grants one
// requester at a time, launches its byte, returns the reply and enforces CS recovery.
module spi_arbiter #(
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] tx0,
  input  logic [7:0] tx1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] rx0,
  output logic [7:0] rx1,
  output logic       err,
  output logic [1:0] grant,
  output logic       spi_start,
  output logic [7:0] spi_tx,
  input  logic       spi_busy,
  input  logic       spi_done,
  input  logic [7:0] spi_rx
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    ACK    = 3'd3,
    GAP    = 3'd4
  } state_t;

  localparam logic [9:0]  TMO_LAST = 10'(TIMEOUT - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

  state_t      state;
  logic        last;
  logic [9:0]  tmo_cnt;
  logic [15:0] gap_cnt;

  // last = 1 means requester 1 was served most recently, so requester 0 wins a tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      tmo_cnt   <= '0;
      gap_cnt   <= '0;
      grant     <= 2'b00;
      spi_tx    <= 8'h00;
      spi_start <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      err       <= 1'b0;
      rx0       <= 8'h00;
      rx1       <= 8'h00;
    end else begin
      spi_start <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      err       <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 && (!req1 || last)) begin
            grant  <= 2'b01;
            spi_tx <= tx0;
            state  <= LAUNCH;
          end else if (req1) begin
            grant  <= 2'b10;
            spi_tx <= tx1;
            state  <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (!spi_busy) begin
            spi_start <= 1'b1;
            tmo_cnt   <= '0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          // A completion arriving on the expiry cycle still counts as success.
          if (spi_done) begin
            if (grant[1]) rx1 <= spi_rx;
            else          rx0 <= spi_rx;
            ack0  <= grant[0];
            ack1  <= grant[1];
            state <= ACK;
          end else if (tmo_cnt == TMO_LAST) begin
            ack0  <= grant[0];
            ack1  <= grant[1];
            err   <= 1'b1;
            state <= ACK;
          end else begin
            tmo_cnt <= tmo_cnt + 10'd1;
          end
        end
        ACK: begin
          last    <= grant[1];
          grant   <= 2'b00;
          gap_cnt <= '0;
          state   <= (GAP_CYCLES == 0) ? IDLE : GAP;
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) state   <= IDLE;
          else                     gap_cnt <= gap_cnt + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// Self-checking bench for spi_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a timestamp-based reference model.
module tb_spi_arbiter;
  localparam int GAP = 4;
  localparam int TMO = 1023;

  logic       clk = 1'b0;
  logic       rst, req0, req1, spi_busy, spi_done;
  logic [7:0] tx0, tx1, spi_rx;
  logic       ack0, ack1, err, spi_start;
  logic [7:0] rx0, rx1, spi_tx;
  logic [1:0] grant;

  spi_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .tx0(tx0), .tx1(tx1),
    .ack0(ack0), .ack1(ack1), .rx0(rx0), .rx1(rx1), .err(err), .grant(grant),
    .spi_start(spi_start), .spi_tx(spi_tx), .spi_busy(spi_busy),
    .spi_done(spi_done), .spi_rx(spi_rx)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit checking = 0;

  int         st_cyc[$];
  logic [7:0] st_tx[$];
  int         ak_cyc[$];
  int         ak_who[$];
  bit         ak_err[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic r0, input logic r1, input logic [7:0] t0,
                               input logic [7:0] t1, input logic b);
    @(negedge clk);
    req0 = r0; req1 = r1; tx0 = t0; tx1 = t1; spi_busy = b;
  endtask

  // Reference model: a transaction is described by who owns the core, when the
  // byte went out on the wire and when the recovery window ends.
  typedef enum {M_FREE, M_QUEUED, M_ONWIRE, M_DONE, M_REST} mphase_t;
  mphase_t    phase = M_FREE;
  int         m_owner, m_last, m_start_t, m_free_t;
  logic [1:0] m_grant, m_ack;
  logic [7:0] m_tx;
  logic [7:0] m_rx[2];
  logic       m_start, m_err;

  task automatic model_step();
    m_start = 1'b0; m_ack = 2'b00; m_err = 1'b0;
    if (rst) begin
      phase = M_FREE; m_grant = 2'b00; m_tx = 8'h00;
      m_rx[0] = 8'h00; m_rx[1] = 8'h00; m_last = 1;
    end else begin
      case (phase)
        M_FREE: if (req0 || req1) begin
          m_owner = (req0 && req1) ? (1 - m_last) : (req1 ? 1 : 0);
          m_grant = (m_owner == 1) ? 2'b10 : 2'b01;
          m_tx    = (m_owner == 1) ? tx1 : tx0;
          phase   = M_QUEUED;
        end
        M_QUEUED: if (!spi_busy) begin
          m_start = 1'b1; m_start_t = cyc; phase = M_ONWIRE;
        end
        M_ONWIRE: if (spi_done) begin
          m_rx[m_owner] = spi_rx; m_ack[m_owner] = 1'b1; phase = M_DONE;
        end else if (cyc - m_start_t == TMO) begin
          m_ack[m_owner] = 1'b1; m_err = 1'b1; phase = M_DONE;
        end
        M_DONE: begin
          m_last = m_owner; m_grant = 2'b00; m_free_t = cyc + GAP;
          phase = (GAP == 0) ? M_FREE : M_REST;
        end
        M_REST: if (cyc == m_free_t) phase = M_FREE;
        default: phase = M_FREE;
      endcase
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    model_step();
    #1;
    if (checking) begin
      checkOutput("outputs_vs_model", {grant, spi_tx, spi_start, ack1, ack0, err, rx1, rx0},
                  {m_grant, m_tx, m_start, m_ack, m_err, m_rx[1], m_rx[0]});
      checkOutput("acks_exclusive", 32'(ack0 & ack1), 0);
      checkOutput("grant_not_11", 32'(grant == 2'b11), 0);
    end
    if (spi_start) begin st_cyc.push_back(cyc); st_tx.push_back(spi_tx); end
    if (ack0 || ack1) begin
      ak_cyc.push_back(cyc); ak_who.push_back(ack1 ? 1 : 0); ak_err.push_back(err);
    end
  end

  // SPI core stand-in: mode 0 fixed delay, 1 random delay (sometimes silent), 2 silent.
  int         core_cnt = 0;
  int         core_mode = 0;
  int         core_delay = 16;
  logic [7:0] core_rx = 8'h55;
  bit         core_rand_rx = 0;
  bit         spurious = 0;

  always @(negedge clk) begin
    spi_done = 1'b0;
    spi_rx   = core_rand_rx ? 8'($urandom) : core_rx;
    if (rst === 1'b1) core_cnt = 0;
    else begin
      if (spi_start === 1'b1) begin
        if (core_mode == 0)      core_cnt = core_delay;
        else if (core_mode == 1) core_cnt = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 20));
      end
      if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) spi_done = 1'b1;
      end else if (spurious && $urandom_range(0, 19) == 0) spi_done = 1'b1;
    end
  end

  task automatic clear_log();
    st_cyc.delete(); st_tx.delete(); ak_cyc.delete(); ak_who.delete(); ak_err.delete();
  endtask

  task automatic wait_acks(input int count, input int limit, input string name);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (ak_cyc.size() >= count) break;
    end
    checkOutput(name, 32'(ak_cyc.size() >= count), 1);
  endtask

  int c0, cfall;

  initial begin
    rst = 1'b1; req0 = 0; req1 = 0; tx0 = 0; tx1 = 0; spi_busy = 0;
    repeat (3) @(negedge clk);
    checking = 1;
    checkOutput("reset_state", {grant, spi_tx, spi_start, ack0, ack1, err, rx0, rx1}, 0);
    @(negedge clk); rst = 1'b0;

    // Single transaction from requester 0, reply after 16 cycles.
    core_mode = 0; core_delay = 16; core_rx = 8'h55;
    clear_log();
    applyStimulus(1, 0, 8'hAA, 8'h00, 0);
    c0 = cyc;
    wait_acks(1, 60, "t1_ack_seen");
    req0 = 0;
    checkOutput("t1_start_count", st_cyc.size(), 1);
    if (st_cyc.size() > 0) begin
      checkOutput("t1_start_latency", st_cyc[0], c0 + 2);
      checkOutput("t1_spi_tx", st_tx[0], 8'hAA);
    end
    if (ak_cyc.size() > 0 && st_cyc.size() > 0) begin
      checkOutput("t1_done_to_ack", ak_cyc[0] - st_cyc[0], 16);
      checkOutput("t1_ack_owner", ak_who[0], 0);
      checkOutput("t1_err", 32'(ak_err[0]), 0);
    end
    checkOutput("t1_rx0", rx0, 8'h55);

    // Core never answers: abort after TIMEOUT cycles, rx0 keeps the old byte.
    core_mode = 2;
    repeat (10) @(negedge clk);
    clear_log();
    applyStimulus(1, 0, 8'h42, 8'h00, 0);
    wait_acks(1, 1100, "t2_ack_seen");
    req0 = 0;
    if (ak_cyc.size() > 0 && st_cyc.size() > 0) begin
      checkOutput("t2_timeout_cycles", ak_cyc[0] - st_cyc[0], 1023);
      checkOutput("t2_err", 32'(ak_err[0]), 1);
      checkOutput("t2_ack_owner", ak_who[0], 0);
    end
    checkOutput("t2_rx0_kept", rx0, 8'h55);

    // Core busy for 20 cycles at grant time.
    core_mode = 0; core_delay = 5; core_rx = 8'h3C;
    repeat (10) @(negedge clk);
    clear_log();
    applyStimulus(0, 1, 8'h00, 8'h5A, 1);
    repeat (20) @(negedge clk);
    spi_busy = 0; cfall = cyc;
    wait_acks(1, 60, "t3_ack_seen");
    req1 = 0;
    checkOutput("t3_start_count", st_cyc.size(), 1);
    if (st_cyc.size() > 0) begin
      checkOutput("t3_start_after_busy", st_cyc[0], cfall + 1);
      checkOutput("t3_spi_tx", st_tx[0], 8'h5A);
    end
    if (ak_cyc.size() > 0) checkOutput("t3_ack_owner", ak_who[0], 1);
    checkOutput("t3_rx1", rx1, 8'h3C);

    // Both requesting from reset: strict alternation, minimum spacing GAP+4.
    @(negedge clk); rst = 1'b1; req0 = 1; req1 = 1; tx0 = 8'h11; tx1 = 8'h22;
    core_delay = 1;
    repeat (2) @(negedge clk);
    clear_log();
    rst = 1'b0;
    wait_acks(4, 200, "t4_four_acks");
    req0 = 0; req1 = 0;
    if (st_cyc.size() >= 4 && ak_who.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        checkOutput($sformatf("t4_tx_%0d", i), st_tx[i], (i % 2) ? 8'h22 : 8'h11);
        checkOutput($sformatf("t4_owner_%0d", i), ak_who[i], i % 2);
        if (i > 0) checkOutput($sformatf("t4_spacing_%0d", i), st_cyc[i] - st_cyc[i-1], GAP + 4);
      end
    end

    // Reset while waiting on the core, then requester 1 alone.
    core_mode = 2;
    repeat (10) @(negedge clk);
    clear_log();
    applyStimulus(1, 0, 8'h99, 8'h00, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (st_cyc.size() > 0) break;
    end
    checkOutput("t5_started", st_cyc.size(), 1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("t5_async_reset", {grant, spi_tx, spi_start, ack0, ack1, err, rx0, rx1}, 0);
    req0 = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("t5_no_ack", ak_cyc.size(), 0);
    core_mode = 0; core_delay = 5; core_rx = 8'hC3;
    applyStimulus(0, 1, 8'h00, 8'h77, 0);
    @(negedge clk);
    checkOutput("t5_grant", grant, 2'b10);
    wait_acks(1, 60, "t5_ack_seen");
    req1 = 0;
    if (ak_cyc.size() > 0) begin
      checkOutput("t5_ack_owner", ak_who[0], 1);
      checkOutput("t5_err", 32'(ak_err[0]), 0);
    end
    checkOutput("t5_rx1", rx1, 8'hC3);

    // Randomized traffic, busy, spurious completions, timeouts and resets.
    core_mode = 1; core_rand_rx = 1; spurious = 1;
    for (int i = 0; i < 4000; i++) begin
      applyStimulus($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
                    8'($urandom), 8'($urandom), $urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 599) == 0);
    end
    @(negedge clk); rst = 1'b0; req0 = 0; req1 = 0;
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 4, idle clk cycles forced between consecutive transactions (CS recovery).
REQ-002 SHALL have parameter TIMEOUT, default 1023, max clk cycles waited for spi_done before abort; counter width 10 bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports req0 / req1  input  1 each  transaction request, level, from requester 0 / 1.
REQ-006 SHALL have ports tx0 / tx1  input  8 each  byte to send for requester 0 / 1, sampled at grant.
REQ-007 SHALL have ports ack0 / ack1  output  1 each  one-cycle completion pulse to requester 0 / 1.
REQ-008 SHALL have ports rx0 / rx1  output  8 each  last byte received on behalf of requester 0 / 1, held until overwritten.
REQ-009 SHALL have port err  output  1  one-cycle pulse coincident with ackN when the transaction timed out.
REQ-010 SHALL have port grant  output  2  one-hot current owner (01 = req0, 10 = req1, 00 = none).
REQ-011 SHALL have ports spi_start  output  1, spi_tx  output  8  launch pulse and byte to the shared SPI master core.
REQ-012 SHALL have ports spi_busy  input  1, spi_done  input  1, spi_rx  input  8  status, one-cycle completion pulse, received byte from the core.

Function
REQ-013 SHALL implement FSM states IDLE, LAUNCH, WAIT, ACK, GAP.
REQ-014 IDLE: if no req, stay; if exactly one req high, grant it; if both high, grant the requester not served last (last-served pointer resets to "1", so req0 wins the first tie).
REQ-015 On grant, SHALL latch txN into spi_tx, set grant one-hot, move to LAUNCH; spi_tx stays constant until next grant.
REQ-016 LAUNCH: while spi_busy=1 stay with spi_start=0; when spi_busy=0 assert spi_start for exactly one cycle and move to WAIT.
REQ-017 Latency: req sampled high in IDLE at edge k with spi_busy=0 -> spi_start high during cycle k+1 to k+2.
REQ-018 WAIT: on spi_done=1, capture spi_rx into rxN of the granted requester, go to ACK; timeout counter cleared on entry.
REQ-019 WAIT: if TIMEOUT cycles elapse without spi_done, go to ACK with err flagged; rxN unchanged.
REQ-020 ACK: pulse ackN (and err if flagged) for one cycle, update last-served pointer, clear grant, go to GAP.
REQ-021 GAP: stay GAP_CYCLES cycles then IDLE; GAP_CYCLES=0 -> ACK goes straight to IDLE.
REQ-022 spi_done outside WAIT SHALL be ignored; spi_done and timeout expiry in same cycle -> treated as success.
REQ-023 Dropping reqN after grant SHALL NOT abort; transaction completes and ackN still pulses.
REQ-024 reqN still high when FSM re-enters IDLE SHALL count as a new request (requesters drop req after ack).
REQ-025 With both requesters continuously requesting, grants SHALL strictly alternate 0,1,0,1,...
REQ-026 ack0 and ack1 SHALL never be high in the same cycle; grant SHALL never be 11.

Reset
REQ-027 rst=1 SHALL immediately force state IDLE, spi_start=0, spi_tx=0, ack0=ack1=0, err=0, grant=00, rx0=rx1=0, counters 0, last-served pointer=1.
REQ-028 Reset mid-transaction SHALL abandon it with no ack; first post-reset grant follows REQ-014.

Verification
REQ-029 req0=1, tx0=8'hAA, model core returns spi_rx=8'h55 with spi_done 16 cycles after start -> spi_tx=8'hAA, one spi_start pulse, rx0=8'h55, one ack0 pulse, err=0.
REQ-030 req0 and req1 held high from reset, tx0=8'h11, tx1=8'h22 -> spi_tx sequence 11,22,11,22; ack0/ack1 alternate; consecutive spi_start pulses separated by at least GAP_CYCLES+4 cycles.
REQ-031 spi_busy held 1 for 20 cycles at grant -> spi_start stays 0 until the cycle after spi_busy falls, then pulses once.
REQ-032 core never asserts spi_done, TIMEOUT=1023 -> ack and err pulse together 1023 cycles after WAIT entry; rxN unchanged.
REQ-033 rst asserted in WAIT -> all outputs zero asynchronously, no ack; after release req1 alone -> grant=10 and normal completion.
